sdc_commutator: RTL
===================

# sdc_commutator

Parametrised single-delay-line commutator for the single-path delay-commutator FFT pipeline. It sits between butterfly stages and reorders a complex sample stream in half-frames of `DELAY` samples. It generates its own switch phase from a valid-qualified counter and advances only on valid samples, so it tolerates stalls. A frame-sync input realigns the phase, and a bypass mode passes samples straight through; it replaces externally driven switch control.

## Interface

Parameters:
- `DELAY`, default 8: delay-line depth in samples and half-frame length, ≥1.
- `CNT_W`, default `max(1,$clog2(DELAY))`: phase counter width. Derived; do not override.

Ports:
- `clk`: input, 1 bit. Single clock, all logic on the rising edge.
- `rst`: input, 1 bit. Reset, synchronous and active-high.
- `din`: input, `fft_pkg::complex_t`. Input sample.
- `din_valid`: input, 1 bit. `din` is a valid sample this cycle.
- `sync`: input, 1 bit. Qualified by `din_valid`; marks `din` as the first sample of a store phase.
- `bypass`: input, 1 bit. Pass-through mode.
- `dout`: output, `fft_pkg::complex_t`. Output sample, registered.
- `dout_valid`: output, 1 bit. `dout` is valid, registered.

## Operation

- State consists of:
  - `phase`, which is STORE or PASS.
  - `cnt`, ranging 0..DELAY-1.
  - `primed`, 1 bit.
  - Delay line `dl[0..DELAY-1]`, whose head is `dl[DELAY-1]`.
- The following applies only on cycles with `din_valid=1` and `bypass=0`:
  - STORE: `dout` is loaded with `dl[DELAY-1]`. The delay line shifts with `din` entering `dl[0]`.
  - PASS: `dout` is loaded with `din`. The delay line shifts with `dl[DELAY-1]` recirculating into `dl[0]`. After DELAY PASS samples the contents are unchanged.
  - Counter: if `cnt==DELAY-1`, then `cnt` is set to 0 and `phase` toggles. Otherwise `cnt` increments.
  - `primed` is set when the last STORE sample (`cnt==DELAY-1`) is accepted.
  - `dout_valid` is loaded with `primed` as it stood before this cycle, OR-ed with `phase==PASS && primed_next`. In effect, output is valid from the first PASS sample after the first completed STORE phase.
- Cycles with `din_valid=0` and `bypass=0`:
  - The delay line, `cnt`, `phase` and `primed` hold.
  - `dout_valid` is loaded with 0.
  - `dout` holds.
- Sync (`sync=1`, `din_valid=1`, `bypass=0`):
  - The sample is processed as STORE with `cnt=0`.
  - The next state is `cnt=1` and `phase=STORE`. For DELAY=1, the next state is `cnt=0` and `phase=PASS`.
  - If the pre-sync state was already `phase==STORE && cnt==0`, sync has no other effect.
  - Otherwise `primed` is cleared before evaluation, so output stays invalid until a full STORE phase has completed.
  - `sync` with `din_valid=0` is ignored.
- Bypass (`bypass=1`):
  - `dout` is loaded with `din` and `dout_valid` with `din_valid`.
  - `phase`, `cnt` and `primed` are forced to their reset values.
  - The delay line holds.
  - `sync` is ignored.
  - Leaving bypass restarts the sequence at STORE with `cnt=0`, unprimed.
- Resulting order for DELAY=D: input blocks A0 B0 A1 B1 … (each D samples) produce output B0 A0 B1 A1 …. This is the half-frame exchange, with A blocks delayed by 2D valid samples.

## Timing

- Reset (`rst=1` at the edge):
  - `dout=0` and `dout_valid=0`.
  - `phase=STORE`, `cnt=0`, `primed=0`.
  - The delay line is not reset.
  - `rst` has priority over `bypass` and `sync`.
- Reset asserted mid-frame discards the frame. After release, the first valid sample is treated as STORE `cnt=0`.
- Latency: `dout` and `dout_valid` update on the edge after the accepting `din_valid` cycle, which is 1 clock.
- There is no backpressure. Every valid input produces exactly one output cycle once primed.
- Gaps in `din_valid` only stretch the timing; they never alter the sample order.
- Phase wrap: the toggle happens on the same edge that accepts sample `cnt==DELAY-1`. The next valid sample uses the new phase.
- Switching `bypass` takes effect on the same edge. Samples of the half-frame in flight in the delay line are lost.

## Test plan

- **Basic reorder (DELAY=4).** Drive samples 0..19 with continuous valid.
  - `dout_valid` is 0 for inputs 0..3.
  - Valid outputs, each one clock after the corresponding input, are 4,5,6,7,0,1,2,3,12,13,14,15,8,9,10,11.
- **Stall tolerance.** Repeat the basic reorder with random `din_valid` gaps (about 40%). The valid output sequence is identical. `dout_valid=0` on the cycle after each gap.
- **Resync.**
  - Drive samples 0..5, then sample 6 with `sync=1`, then 7..18 continuously.
  - Inputs 6..9 are the STORE phase and `dout_valid` is 0 through input 9.
  - The first valid output is 10.
  - Outputs are 10,11,12,13,6,7,8,9,…
- **Redundant sync.** Drive `sync` on sample 0 and sample 8 of the basic sequence. The output is identical to the basic reorder.
- **Bypass.**
  - With `bypass=1`, drive 0..5: `dout` follows `din` with a 1-clock lag and `dout_valid` mirrors `din_valid`.
  - Deassert bypass and drive 0..11: outputs are invalid for 0..3, then 4,5,6,7,0,1,2,3.
- **Reset mid-operation.** Assert `rst` after input 6 of the basic reorder. On the next edge `dout_valid=0` and `dout=0`. Restarting at 0 reproduces the basic reorder output exactly.

Source files
------------

// File: rtl/sdc_commutator.sv
// Single-delay-line commutator for an SDC FFT pipeline: exchanges alternate
// half-frames of DELAY samples, with a self-generated, valid-qualified switch phase.
package fft_pkg;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;
endpackage

module sdc_commutator #(
    parameter int DELAY = 8,
    parameter int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  fft_pkg::complex_t  din,
    input  logic               din_valid,
    input  logic               sync,
    input  logic               bypass,
    output fft_pkg::complex_t  dout,
    output logic               dout_valid,
    output logic               dbg_phase,
    output logic [CNT_W-1:0]   dbg_cnt,
    output logic               dbg_primed
);
    import fft_pkg::*;

    typedef enum logic {STORE = 1'b0, PASS = 1'b1} phase_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             primed_q, primed_d;
    complex_t         dl_q [DELAY];
    complex_t         dl_d [DELAY];
    complex_t         dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    // State seen by the current sample after any sync realignment.
    phase_e           eff_phase;
    logic [CNT_W-1:0] eff_cnt;
    logic             eff_primed;

    always_comb begin
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        primed_d     = primed_q;
        dl_d         = dl_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        eff_phase    = phase_q;
        eff_cnt      = cnt_q;
        eff_primed   = primed_q;

        if (bypass) begin
            dout_d       = din;
            dout_valid_d = din_valid;
            phase_d      = STORE;
            cnt_d        = '0;
            primed_d     = 1'b0;
        end else if (din_valid) begin
            if (sync) begin
                eff_phase = STORE;
                eff_cnt   = '0;
                // A sync landing exactly on the natural frame start keeps the stream primed.
                if (!(phase_q == STORE && cnt_q == '0)) begin
                    eff_primed = 1'b0;
                end
            end

            for (int i = 1; i < DELAY; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            if (eff_phase == STORE) begin
                dout_d   = dl_q[DELAY-1];
                dl_d[0]  = din;
            end else begin
                dout_d   = din;
                dl_d[0]  = dl_q[DELAY-1];
            end

            if (eff_cnt == LAST) begin
                cnt_d   = '0;
                phase_d = (eff_phase == STORE) ? PASS : STORE;
            end else begin
                cnt_d   = eff_cnt + CNT_W'(1);
                phase_d = eff_phase;
            end

            primed_d     = eff_primed | (eff_phase == STORE && eff_cnt == LAST);
            dout_valid_d = eff_primed | (eff_phase == PASS && primed_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= STORE;
            cnt_q        <= '0;
            primed_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            primed_q     <= primed_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Delay-line contents are don't-care until a full STORE phase refills them.
    always_ff @(posedge clk) begin
        dl_q <= dl_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dbg_phase  = phase_q;
    assign dbg_cnt    = cnt_q;
    assign dbg_primed = primed_q;

endmodule
